// File: rtl/red_pitaya_lpf_inverse_block.sv
// red_pitaya_lpf_inverse_block: inverse of the first-order IIR lowpass, x[n-1] = y[n-1] + (y[n]-y[n-1])*2^g
// Ports:
//   clk_i      system clock (125 MHz)
//   rstn_i     asynchronous active-low reset
//   shift      lowpass shift code, g = MAXSHIFT-shift (0 when shift >= MAXSHIFT)
//   filter_on  1 engages the inverse filter, 0 selects passthrough
//   signal_i   signed lowpassed input
//   signal_o   signed output, 2 clk after signal_i in every state
//   active_o   high while the inverse output is in use
//   sat_o      high on each cycle the inverse output was clipped
module red_pitaya_lpf_inverse_block #(
    parameter int SHIFTBITS     = 4,
    parameter int SIGNALBITS    = 14,
    parameter int MINBW         = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic        [SHIFTBITS:0]    shift,
    input  logic                         filter_on,
    input  logic signed [SIGNALBITS-1:0] signal_i,
    output logic signed [SIGNALBITS-1:0] signal_o,
    output logic                         active_o,
    output logic                         sat_o
);
    localparam int MAXSHIFT = $clog2(125000000 / MINBW);
    localparam int SC       = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW       = (SC < 2) ? 1 : $clog2(SC);
    localparam int SCM1     = SC - 1;
    localparam logic [CW-1:0]      RELOAD = SCM1[CW-1:0];
    localparam logic [SHIFTBITS:0] MAXS   = MAXSHIFT[SHIFTBITS:0];

    typedef logic signed [SIGNALBITS:0]            diff_t;
    typedef logic signed [SIGNALBITS+MAXSHIFT:0]   scl_t;
    typedef logic signed [SIGNALBITS+MAXSHIFT+1:0] sum_t;
    typedef enum logic [1:0] {OFF, SETTLE, ACTIVE} state_t;

    localparam sum_t SMAX = sum_t'(2 ** (SIGNALBITS - 1) - 1);
    localparam sum_t SMIN = sum_t'(-(2 ** (SIGNALBITS - 1)));
    localparam logic signed [SIGNALBITS-1:0] MAXV = {1'b0, {(SIGNALBITS-1){1'b1}}};
    localparam logic signed [SIGNALBITS-1:0] MINV = {1'b1, {(SIGNALBITS-1){1'b0}}};

    state_t                         state, state_nx;
    logic        [CW-1:0]           cnt, cnt_nx;
    logic        [SHIFTBITS:0]      shift_l, shift_l_nx, g;
    logic signed [SIGNALBITS-1:0]   x_d1, x_d2, sig_nx;
    diff_t                          d;
    scl_t                           scaled;
    sum_t                           sum;
    logic                           use_inv, sat_nx;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= OFF;
            cnt     <= '0;
            shift_l <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            shift_l <= shift_l_nx;
        end
    end

    // filter_on=0 wins over a shift change, which wins over counter expiry
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift_l_nx = shift_l;
        if (!filter_on) begin
            state_nx = OFF;
        end else if (state == OFF || shift != shift_l) begin
            state_nx   = SETTLE;
            cnt_nx     = RELOAD;
            shift_l_nx = shift;
        end else if (state == SETTLE) begin
            if (cnt == '0) state_nx = ACTIVE;
            else cnt_nx = cnt - 1'b1;
        end
    end

    always_comb begin
        active_o = (state == ACTIVE);
        use_inv  = (state == ACTIVE);
    end

    // only the latched shift drives the gain, so shift glitches never reach the datapath
    always_comb begin
        g      = (shift_l >= MAXS) ? '0 : MAXS - shift_l;
        scaled = scl_t'(d) <<< g;
        sum    = sum_t'(x_d2) + sum_t'(scaled);
        sat_nx = use_inv && (sum > SMAX || sum < SMIN);
        sig_nx = !use_inv   ? x_d1 :
                 sum > SMAX ? MAXV :
                 sum < SMIN ? MINV : sum[SIGNALBITS-1:0];
    end

    // passthrough re-registers x_d1, matching the 2-clk latency of the inverse path
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_d1     <= '0;
            x_d2     <= '0;
            d        <= '0;
            signal_o <= '0;
            sat_o    <= 1'b0;
        end else begin
            x_d1     <= signal_i;
            x_d2     <= x_d1;
            d        <= diff_t'(signal_i) - diff_t'(x_d1);
            signal_o <= sig_nx;
            sat_o    <= sat_nx;
        end
    end
endmodule
